// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue -- issue stage in front of the MiniALU datapath.
//
// Buffers ALU commands from a valid/ready source in a DEPTH-entry FIFO,
// issues at most one per cycle to the ALU (alu_en pulse + registered
// operands), captures alu_y/alu_flags ALU_LAT cycles later into a response
// FIFO and returns them in command order on a valid/ready response port.
// A credit counter (ALU_LAT+1 credits) bounds in-flight + buffered results
// so the response FIFO can never overflow.
//
// Handshake rule (both ports): a transfer happens at a rising clk edge when
// valid and ready are both high; valid-side payload is held until then.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op, cmd_a, cmd_b, cmd_carry_in, cmd_sat, cmd_cmp_mode, cmd_shift
//                            command payload
//   alu_en                   one-cycle issue pulse to the ALU
//   alu_op, alu_a, alu_b, alu_carry_in, alu_sat, alu_cmp_mode, alu_shift_amt
//                            registered operands, held until the next issue
//   alu_y, alu_flags         ALU result / {carry_out, zero, negative, cmp_out}
//   rsp_valid/rsp_ready      response handshake
//   rsp_y, rsp_flags         response payload (head of the response FIFO)
//   busy                     any command, in-flight op or response pending
//
// Optional feature macro: ALU_ISSUE_STATS_EN adds issue_count and
// stall_count (16-bit, saturating) outputs.

module alu_cmd_issue #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_carry_in,
  input  logic             cmd_sat,
  input  logic [1:0]       cmd_cmp_mode,
  input  logic [2:0]       cmd_shift,
  output logic             alu_en,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_carry_in,
  output logic             alu_sat,
  output logic [1:0]       alu_cmp_mode,
  output logic [2:0]       alu_shift_amt,
  input  logic [WIDTH-1:0] alu_y,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic [3:0]       rsp_flags,
  output logic             busy
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]      issue_count,
  output logic [15:0]      stall_count
`endif
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = 3 + 2 * WIDTH + 1 + 1 + 2 + 3;
  localparam int RD  = ALU_LAT + 1;
  localparam int RIW = $clog2(RD);
  localparam int RCW = $clog2(RD + 1);

  // Command FIFO
  logic [CW-1:0]  cmd_mem [DEPTH];
  logic [PW:0]    wr_ptr;
  logic [PW:0]    wr_vis;
  logic [PW:0]    rd_ptr;
  logic           cmd_full;
  logic           cmd_empty;
  logic           cmd_issuable;
  logic           cmd_push;
  logic [CW-1:0]  head;

  // Issue / tracking
  logic [RCW-1:0]     credits;
  logic               credit_ok;
  logic               issue;
  logic [ALU_LAT-1:0] fly;
  logic               capture;

  // Response FIFO
  logic [WIDTH+3:0] rsp_mem [RD];
  logic [RIW-1:0]   rsp_wr;
  logic [RIW-1:0]   rsp_rd;
  logic [RCW-1:0]   rsp_cnt;
  logic             rsp_pop;

  function automatic logic [RIW-1:0] rsp_next(input logic [RIW-1:0] idx);
    return (idx == RIW'(RD - 1)) ? '0 : idx + RIW'(1);
  endfunction

  assign cmd_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign cmd_empty = (wr_ptr == rd_ptr);
  // An entry becomes issuable one cycle after it is written (registered-read
  // storage), which gives the ALU_LAT+2 accept-to-response latency.
  assign cmd_issuable = (wr_vis != rd_ptr);
  assign cmd_ready    = !rst && !cmd_full;
  assign cmd_push     = cmd_valid && cmd_ready;
  assign head         = cmd_mem[rd_ptr[PW-1:0]];

  assign rsp_valid = (rsp_cnt != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  // A response popped this cycle frees its slot at the same edge.
  assign credit_ok = (credits != '0) || rsp_pop;
  assign issue     = cmd_issuable && credit_ok;
  assign alu_en    = fly[0];
  assign capture   = fly[ALU_LAT-1];
  assign busy      = !cmd_empty || (|fly) || rsp_valid;
  assign {rsp_flags, rsp_y} = rsp_valid ? rsp_mem[rsp_rd] : '0;

  always_ff @(posedge clk) begin
    if (cmd_push)
      cmd_mem[wr_ptr[PW-1:0]] <= {cmd_op, cmd_a, cmd_b, cmd_carry_in, cmd_sat,
                                  cmd_cmp_mode, cmd_shift};
  end

  always_ff @(posedge clk) begin
    if (capture)
      rsp_mem[rsp_wr] <= {alu_flags, alu_y};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      wr_vis        <= '0;
      rd_ptr        <= '0;
      credits       <= RCW'(RD);
      fly           <= '0;
      alu_op        <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_carry_in  <= 1'b0;
      alu_sat       <= 1'b0;
      alu_cmp_mode  <= '0;
      alu_shift_amt <= '0;
      rsp_wr        <= '0;
      rsp_rd        <= '0;
      rsp_cnt       <= '0;
    end else begin
      wr_ptr <= wr_ptr + (PW + 1)'(cmd_push);
      wr_vis <= wr_ptr;
      if (issue) begin
        rd_ptr <= rd_ptr + (PW + 1)'(1);
        {alu_op, alu_a, alu_b, alu_carry_in, alu_sat, alu_cmp_mode, alu_shift_amt} <= head;
      end
      // fly[k] set means an op issued k+1 edges ago is still in the ALU.
      fly     <= (fly << 1) | ALU_LAT'(issue);
      credits <= credits - RCW'(issue) + RCW'(rsp_pop);
      if (capture) rsp_wr <= rsp_next(rsp_wr);
      if (rsp_pop) rsp_rd <= rsp_next(rsp_rd);
      rsp_cnt <= rsp_cnt + RCW'(capture) - RCW'(rsp_pop);
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic stall;
  assign stall = !cmd_empty && !credit_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_count <= '0;
      stall_count <= '0;
    end else begin
      if (issue && issue_count != 16'hFFFF) issue_count <= issue_count + 16'd1;
      if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: drives random ALU commands, models the ALU
// behind the issue port, and checks responses against an expected queue
// built from the accepted commands, plus latency, credit and reset rules.
module tb_alu_cmd_issue;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = '0;
  logic [WIDTH-1:0] cmd_a = '0;
  logic [WIDTH-1:0] cmd_b = '0;
  logic             cmd_carry_in = 1'b0;
  logic             cmd_sat = 1'b0;
  logic [1:0]       cmd_cmp_mode = '0;
  logic [2:0]       cmd_shift = '0;
  logic             alu_en;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_carry_in;
  logic             alu_sat;
  logic [1:0]       alu_cmp_mode;
  logic [2:0]       alu_shift_amt;
  logic [WIDTH-1:0] alu_y;
  logic [3:0]       alu_flags;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_y;
  logic [3:0]       rsp_flags;
  logic             busy;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]      issue_count;
  logic [15:0]      stall_count;
`endif

  alu_cmd_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_carry_in(cmd_carry_in),
    .cmd_sat(cmd_sat), .cmd_cmp_mode(cmd_cmp_mode), .cmd_shift(cmd_shift),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_carry_in(alu_carry_in), .alu_sat(alu_sat), .alu_cmp_mode(alu_cmp_mode),
    .alu_shift_amt(alu_shift_amt), .alu_y(alu_y), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_flags(rsp_flags),
    .busy(busy)
`ifdef ALU_ISSUE_STATS_EN
    , .issue_count(issue_count), .stall_count(stall_count)
`endif
  );

  // ---------------- ALU model: returns {flags, y} ----------------
  function automatic logic [11:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin, input logic sat,
                                        input logic [1:0] cmp, input logic [2:0] sh);
    logic [8:0] s;
    logic [7:0] y;
    logic       c;
    logic       k;
    s = '0; c = 1'b0; y = '0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b} + {8'd0, cin}; y = s[7:0]; c = s[8]; if (sat && c) y = 8'hFF; end
      3'd1: begin s = {1'b0, a} - {1'b0, b} - {8'd0, cin}; y = s[7:0]; c = s[8]; if (sat && c) y = 8'h00; end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = a << sh;
      3'd6: y = a >> sh;
      default: y = a;
    endcase
    case (cmp)
      2'd0: k = (a == b);
      2'd1: k = (a < b);
      2'd2: k = (a > b);
      default: k = ($signed(a) < $signed(b));
    endcase
    return {c, (y == 8'h00), y[7], k, y};
  endfunction

  assign {alu_flags, alu_y} = alu_f(alu_op, alu_a, alu_b, alu_carry_in, alu_sat,
                                    alu_cmp_mode, alu_shift_amt);

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int en_cnt = 0, acc_cnt = 0, rsp_cnt = 0, nready_cnt = 0, stall_exp = 0;
  bit stat_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor at negedge: values seen here are those consumed at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      en_cnt = 0; acc_cnt = 0; rsp_cnt = 0; stall_exp = 0;
    end else begin
      int occ;
      int outstanding;
      logic [11:0] e;
      if (alu_en) en_cnt++;
`ifdef ALU_ISSUE_STATS_EN
      if (stat_chk) begin
        check("issue_count", 32'(issue_count), 32'(en_cnt));
        check("stall_count", 32'(stall_count), 32'(stall_exp));
        stat_chk = 1'b0;
      end
`endif
      // Credits in use = issued but not yet returned to the consumer.
      occ = acc_cnt - en_cnt;
      outstanding = en_cnt - rsp_cnt;
      if (occ > 0 && outstanding == ALU_LAT + 1 && !(rsp_valid && rsp_ready)) stall_exp++;
      if (cmd_valid && !cmd_ready) nready_cnt++;
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(alu_f(cmd_op, cmd_a, cmd_b, cmd_carry_in, cmd_sat, cmd_cmp_mode, cmd_shift));
        acc_cnt++;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) check("rsp_unexpected", 32'(1), 32'(0));
        else begin
          e = exp_q.pop_front();
          check("rsp_data", 32'({rsp_flags, rsp_y}), 32'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rand_cmd();
    cmd_op       = 3'($urandom_range(0, 7));
    cmd_a        = 8'($urandom_range(0, 255));
    cmd_b        = 8'($urandom_range(0, 255));
    cmd_carry_in = 1'($urandom_range(0, 1));
    cmd_sat      = 1'($urandom_range(0, 1));
    cmd_cmp_mode = 2'($urandom_range(0, 3));
    cmd_shift    = 3'($urandom_range(0, 7));
  endtask

  task automatic send();
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!ok) check("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n_exp);
    int base;
    base = rsp_cnt;
    rsp_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (rsp_cnt - base >= n_exp && !busy) break;
    end
    check("drain_count", 32'(rsp_cnt - base), 32'(n_exp));
    check("drain_q_empty", 32'(exp_q.size()), 32'(0));
    check("drain_idle", 32'(busy), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0, a0, n0, c0, lat, k;
    bit done;

    // 1. reset, then a single add 5+3
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    check("rst_alu_en", 32'(alu_en), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_rsp_y", 32'(rsp_y), 32'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));

    cmd_op = 3'd0; cmd_a = 8'h05; cmd_b = 8'h03; cmd_carry_in = 1'b0;
    cmd_sat = 1'b0; cmd_cmp_mode = 2'd0; cmd_shift = 3'd0;
    e0 = en_cnt;
    send();
    lat = 0;
    while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    check("single_latency", 32'(lat), 32'(ALU_LAT + 2));
    check("single_rsp_y", 32'(rsp_y), 32'h08);
    check("single_en_pulses", 32'(en_cnt - e0), 32'(1));
    drain(1);

    // 2. back-to-back stream of 16 with rsp_ready high
    rsp_ready = 1'b1;
    n0 = nready_cnt; c0 = cyc; a0 = rsp_cnt;
    for (int i = 0; i < 16; i++) begin rand_cmd(); send(); end
    check("stream_accept_cycles", 32'(cyc - c0), 32'(16));
    check("stream_ready_drop", 32'(nready_cnt - n0), 32'(0));
    for (int i = 0; i < 20; i++) begin
      if (rsp_cnt - a0 >= 16) break;
      @(posedge clk); #1;
    end
    check("stream_throughput", 32'(rsp_cnt - a0), 32'(16));
    drain(0);

    // 3. rsp_ready low, keep pushing until the FIFO is full
    rsp_ready = 1'b0;
    e0 = en_cnt; a0 = acc_cnt; k = 0;
    rand_cmd();
    cmd_valid = 1'b1;
    for (int i = 0; i < 60 && k < 8; i++) begin
      @(negedge clk);
      if (cmd_ready) k = 0; else k++;
      @(posedge clk); #1;
      rand_cmd();
    end
    check("fill_accepts", 32'(acc_cnt - a0), 32'(DEPTH + ALU_LAT + 1));
    check("fill_issues", 32'(en_cnt - e0), 32'(ALU_LAT + 1));
    check("fill_cmd_ready", 32'(cmd_ready), 32'(0));
    check("fill_alu_en_low", 32'(alu_en), 32'(0));
    stat_chk = 1'b1;
    idle(2);
    cmd_valid = 1'b0;
    drain(DEPTH + ALU_LAT + 1);

    // 4. random traffic with random back-pressure, wraps pointers many times
    done = 1'b0;
    a0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          rand_cmd(); send();
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    check("random_accepts", 32'(acc_cnt - a0), 32'(40));
    drain(exp_q.size());

    // 5. reset while operations are in flight and a response is pending
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_cmd(); send(); end
    idle(1);
    check("pre_rst_busy", 32'(busy), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'(0));
    check("mid_rst_alu_en", 32'(alu_en), 32'(0));
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_rsp_data", 32'({rsp_flags, rsp_y}), 32'(0));
    check("mid_rst_alu_a", 32'(alu_a), 32'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rel_busy", 32'(busy), 32'(0));
    check("rel_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rel_cmd_ready", 32'(cmd_ready), 32'(1));
    idle(3);
    check("rel_no_stale_rsp", 32'(rsp_valid), 32'(0));
    e0 = en_cnt;
    for (int i = 0; i < 4; i++) begin rand_cmd(); send(); end
    idle(6);
    check("rel_credits_full", 32'(en_cnt - e0), 32'(ALU_LAT + 1));
    drain(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
